// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 single-bit multiplexer.
//   N_IN    : number of data lanes (fixed at 4)
//   SEL_W   : select width, log2(N_IN)
//   sel_t   : lane select code type
//   lanes_t : data lane / one-hot vector type
package mux_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_IN-1:0]  lanes_t;

endpackage : mux_pkg

// File: rtl/mux_4_1_dec2to4.sv
// 2-to-4 one-hot decoder for the multiplexer lane select.
// Ports:
//   sel : input  sel_t   lane select code 0..3
//   oh  : output lanes_t one-hot decode, oh[k] = (sel == k)
module dec2to4
  import mux_pkg::*;
(
  input  sel_t   sel,
  output lanes_t oh
);

  // Each bit is an equality compare rather than a case with a default arm,
  // so an unknown select bit yields unknown decode bits instead of quietly
  // choosing a lane.
  for (genvar k = 0; k < N_IN; k++) begin : g_dec
    assign oh[k] = (sel == sel_t'(k));
  end

endmodule : dec2to4

// File: rtl/mux_4_1.sv
// Four-input, one-bit multiplexer with a registered copy of its output.
// Ports:
//   clk : input  rising-edge clock
//   rst : input  synchronous active-high reset, clears y_q
//   a   : input  [3:0] data lanes, a[k] is lane k
//   sel : input  [1:0] lane select
//   y   : output combinational a[sel]
//   y_q : output a[sel] captured at the previous rising clk edge
module mux_4_1
  import mux_pkg::*;
#(
  parameter int N_IN  = 4,  // fixed; must match the package constant
  parameter int SEL_W = 2   // log2(N_IN)
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  a,
  input  logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_q
);

  lanes_t oh;
  logic   y_p0;
  logic   y_p1;

  dec2to4 u_dec (
    .sel (sel_t'(sel)),
    .oh  (oh)
  );

  // Stage p0: AND-OR select, no priority chain between lanes.
  assign y_p0 = |(lanes_t'(a) & oh);
  assign y    = y_p0;

  // Stage p1: clock-aligned copy of the selected lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1 <= 1'b0;
    end else begin
      y_p1 <= y_p0;
    end
  end

  assign y_q = y_p1;

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) !$isunknown(sel) |-> $onehot(oh));
  a_select : assert property (@(posedge clk) !$isunknown(sel) |-> (y == a[sel]));
`endif

endmodule : mux_4_1

// File: tb/tb_mux_4_1.sv
module tb_mux_4_1;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [1:0] sel;
  logic       y;
  logic       y_q;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0] a;
    logic [1:0] sel;
    logic       exp_y;
  } vec_t;

  vec_t vecs[$];

  mux_4_1 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .sel (sel),
    .y   (y),
    .y_q (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit 'sel' of the lane word, by shifting.
  function automatic logic ref_y(input logic [3:0] av, input logic [1:0] sv);
    int v;
    v = int'(av) >> int'(sv);
    return (v % 2) == 1;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (a=%b sel=%0d t=%0t)", nm, act, exp, a, sel, $time);
    end
  endtask

  initial begin
    logic exp_prev;
    logic [3:0] av;
    n_chk  = 0;
    n_fail = 0;

    // Directed table: spec examples plus walking one / walking zero.
    vecs.push_back('{4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b1011, 2'd2, 1'b0});
    for (int k = 0; k < 4; k++) begin
      av = 4'b0001 << k;
      vecs.push_back('{av, 2'(k), 1'b1});
      vecs.push_back('{~av, 2'(k), 1'b0});
    end

    // Reset with all lanes high: y follows inputs, y_q held at 0.
    rst = 1'b1; a = 4'b1111; sel = 2'd3;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_yq", y_q, 1'b0);
    chk("reset_y", y, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release_yq", y_q, 1'b1);

    // Directed table.
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a; sel = vecs[i].sel;
      #1 chk("table_y", y, vecs[i].exp_y);
    end

    // Exhaustive combinational sweep, 10 time units per step.
    @(negedge clk);
    a = 4'd0; sel = 2'd0;
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 16; v++) begin
        a = 4'(v); sel = 2'(s);
        #1 chk("sweep_y", y, ref_y(4'(v), 2'(s)));
        #9;
      end
    end

    // Random stimulus: y checked immediately, y_q one cycle later.
    @(negedge clk);
    a = 4'($urandom); sel = 2'($urandom);
    exp_prev = ref_y(a, sel);
    #1 chk("rand_y", y, exp_prev);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rand_yq", y_q, exp_prev);
      a = 4'($urandom); sel = 2'($urandom);
      exp_prev = ref_y(a, sel);
      #1 chk("rand_y", y, exp_prev);
    end

    // Registered latency: toggle a[1] every cycle at sel=1.
    @(negedge clk);
    sel = 2'd1; a = 4'b0000;
    exp_prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("latency_yq", y_q, exp_prev);
      a[1] = ~a[1];
      exp_prev = a[1];
      #1 chk("latency_y", y, exp_prev);
    end

    // Simultaneous change of a and sel.
    @(negedge clk);
    a = 4'b0001; sel = 2'd0;
    @(negedge clk);
    chk("simul_pre_yq", y_q, 1'b1);
    a = 4'b1000; sel = 2'd3;
    #1 chk("simul_y", y, 1'b1);
    @(posedge clk); #1;
    chk("simul_yq", y_q, 1'b1);

    // Mid-run reset with all lanes high.
    @(negedge clk);
    a = 4'b1111; sel = 2'd2;
    @(negedge clk);
    chk("midrst_pre_yq", y_q, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_yq", y_q, 1'b0);
    chk("midrst_y", y, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_recover_yq", y_q, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_4_1
